// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks an N-bit word LSB first,
// carrying between bits in a register and shifting the sum into place.

module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out,
  output logic [1:0]          fsm_state
);

  localparam int CNT_W = $clog2(NUM_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NUM_BITS-1:0] a_sr, b_sr, res_sr;
  logic                c_reg;
  logic [CNT_W-1:0]    cnt;
  logic                add_s, add_c;
  logic                last_bit;

  // Handshake: start is a request sampled only while IDLE; done is a one-cycle
  // pulse with sum/carry_out valid, and those outputs hold until the next
  // completing edge. There is no backpressure on the result.

  adder_1bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_reg),
    .s    (add_s),
    .cout (add_c)
  );

  assign last_bit  = (cnt == CNT_W'(NUM_BITS - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            c_reg <= carry_in;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c_reg  <= add_c;
          res_sr <= {add_s, res_sr[NUM_BITS-1:1]};
          // Wrap to zero rather than overflow so cnt stays within 0..NUM_BITS-1.
          cnt    <= last_bit ? '0 : cnt + 1'b1;
          if (last_bit) begin
            sum       <= {add_s, res_sr[NUM_BITS-1:1]};
            carry_out <= add_c;
          end
        end
        default: ;
      endcase
    end
  end

  a_operands_known : assert property (
    @(posedge clk) disable iff (!n_rst)
      (state == IDLE && start) |-> !$isunknown({a, b, carry_in})
  ) else $error("serial_adder_ctrl: X/Z operand on accepted start");

endmodule
